// File: rtl/sample_stats.sv
// Purpose : per-channel windowed mean (dc) and high-magnitude fraction (mag) over 2^LOG2N valid samples.
// Latency : results appear one clock after the sample that completes the window; stats_valid pulses for that one cycle.
// Backpress: none; every x_valid sample is consumed, and x_valid=0 cycles leave the window state untouched.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   x, x_valid        NCH packed W-bit two's-complement samples, channel c at x[c*W +: W]
//   thresh            unsigned magnitude threshold shared by all channels
//   clear             synchronous window restart; discards the partial window and beats a coincident publish
//   dc, mag           per-channel published mean (FRAC fractional bits) and saturated high-sample fraction
//   stats_valid       one-cycle pulse following each publish
//   frame             publish counter, wraps 255 -> 0
module sample_stats #(
  parameter int NCH   = 2,
  parameter int W     = 8,
  parameter int LOG2N = 19,
  parameter int FRAC  = 3,
  parameter int HW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*W-1:0]        x,
  input  logic                    x_valid,
  input  logic [W-2:0]            thresh,
  input  logic                    clear,
  output logic [NCH*(W+FRAC)-1:0] dc,
  output logic [NCH*HW-1:0]       mag,
  output logic                    stats_valid,
  output logic [7:0]              frame
);

  localparam int AW = W + LOG2N;  // accumulator width, cannot overflow over one window
  localparam int DW = W + FRAC;   // published mean width

  logic [LOG2N-1:0] cnt;
  logic             publish;

  // The completing sample is the valid one seen while the counter is all ones;
  // a simultaneous clear suppresses the publish entirely.
  assign publish = x_valid && !clear && (cnt == {LOG2N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame       <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= publish;
      if (clear) begin
        cnt <= '0;
      end else if (x_valid) begin
        // Wraps to zero naturally on the completing sample.
        cnt <= cnt + LOG2N'(1);
      end
      if (publish) begin
        frame <= frame + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [W-1:0]  xs;
    logic signed [W:0]    xe;
    logic signed [W:0]    te;
    logic                 high;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [LOG2N:0]       hcnt;
    logic [LOG2N:0]       hnext;
    logic [LOG2N:0]       hsh;
    logic [HW-1:0]        mag_next;
    logic [DW-1:0]        dc_r;
    logic [HW-1:0]        mag_r;
    logic                 unused_sum;

    assign xs = x[c*W +: W];

    // One extra bit lets -thresh and the most-negative code coexist exactly.
    assign xe   = {xs[W-1], xs};
    assign te   = {2'b00, thresh};
    assign high = (xe >= te) || (xe <= -te);

    // sum and hnext already include the current sample, so a publish
    // captures the completing sample without an extra cycle.
    assign sum   = acc + {{LOG2N{xs[W-1]}}, xs};
    assign hnext = hcnt + {{LOG2N{1'b0}}, high};

    // An all-high window reaches 2^LOG2N, one past the HW-bit range.
    assign hsh      = hnext >> (LOG2N - HW);
    assign mag_next = (|hsh[LOG2N:HW]) ? {HW{1'b1}} : hsh[HW-1:0];

    // The bits below the kept fraction are intentionally dropped (floor).
    assign unused_sum = ^sum;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc   <= '0;
        hcnt  <= '0;
        dc_r  <= '0;
        mag_r <= '0;
      end else begin
        if (clear) begin
          acc  <= '0;
          hcnt <= '0;
        end else if (x_valid) begin
          if (publish) begin
            acc  <= '0;
            hcnt <= '0;
          end else begin
            acc  <= sum;
            hcnt <= hnext;
          end
        end
        if (publish) begin
          dc_r  <= sum[AW-1 -: DW];
          mag_r <= mag_next;
        end
      end
    end

    assign dc[c*DW +: DW] = dc_r;
    assign mag[c*HW +: HW] = mag_r;
  end

endmodule

// File: tb/tb_sample_stats.sv
// Purpose : self-checking bench for sample_stats (NCH=2, W=8, LOG2N=4, FRAC=3, HW=4).
// Latency : outputs compared 1 time unit after every rising edge against an arithmetic window model.
// Backpress: not applicable; the bench drives x_valid patterns directly.
module tb_sample_stats;

  localparam int NCH   = 2;
  localparam int W     = 8;
  localparam int LOG2N = 4;
  localparam int FRAC  = 3;
  localparam int HW    = 4;
  localparam int WIN   = 1 << LOG2N;
  localparam int DW    = W + FRAC;
  localparam int MAGMX = (1 << HW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NCH*W-1:0]     x = '0;
  logic                 x_valid = 1'b0;
  logic [W-2:0]         thresh = '0;
  logic                 clear = 1'b0;
  logic [NCH*DW-1:0]    dc;
  logic [NCH*HW-1:0]    mag;
  logic                 stats_valid;
  logic [7:0]           frame;

  bit clk_run = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  int pubs    = 0;

  sample_stats #(.NCH(NCH), .W(W), .LOG2N(LOG2N), .FRAC(FRAC), .HW(HW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .x_valid     (x_valid),
    .thresh      (thresh),
    .clear       (clear),
    .dc          (dc),
    .mag         (mag),
    .stats_valid (stats_valid),
    .frame       (frame)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  // ---------------- reference model: samples summed per window ----------------
  int m_sum [NCH];
  int m_hi  [NCH];
  int m_n;
  int m_dc  [NCH];
  int m_mag [NCH];
  int m_frame;
  int m_sv;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_window_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sum[c] = 0;
      m_hi[c]  = 0;
    end
    m_n = 0;
  endtask

  task automatic model_full_reset();
    model_window_reset();
    for (int c = 0; c < NCH; c++) begin
      m_dc[c]  = 0;
      m_mag[c] = 0;
    end
    m_frame = 0;
    m_sv    = 0;
  endtask

  task automatic model_edge(input logic [NCH*W-1:0] xv, input logic v, input int th, input logic clr);
    int s;
    int m;
    m_sv = 0;
    if (clr) begin
      model_window_reset();
    end else if (v) begin
      for (int c = 0; c < NCH; c++) begin
        s = int'($signed(xv[c*W +: W]));
        m_sum[c] += s;
        if (((s < 0) ? -s : s) >= th) m_hi[c]++;
      end
      m_n++;
      if (m_n == WIN) begin
        for (int c = 0; c < NCH; c++) begin
          m_dc[c] = floor_div(m_sum[c] * (1 << FRAC), WIN);
          m      = (m_hi[c] * (1 << HW)) / WIN;
          m_mag[c] = (m > MAGMX) ? MAGMX : m;
        end
        m_frame = (m_frame + 1) % 256;
        m_sv    = 1;
        model_window_reset();
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("stats_valid", int'(stats_valid), m_sv);
    check("frame", int'(frame), m_frame);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("dc[%0d]", c), int'($signed(dc[c*DW +: DW])), m_dc[c]);
      check($sformatf("mag[%0d]", c), int'(mag[c*HW +: HW]), m_mag[c]);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare DUT against the model.
  task automatic step(input int x0v, input int x1v, input logic v, input int th, input logic clr);
    logic [NCH*W-1:0] xv;
    xv      = {W'(x1v), W'(x0v)};
    x       = xv;
    x_valid = v;
    thresh  = (W-1)'(th);
    clear   = clr;
    @(posedge clk);
    #1;
    model_edge(xv, v, th, clr);
    compare_all();
  endtask

  task automatic check_pub(input string tag, input int sv, input int d0, input int d1,
                           input int g0, input int g1, input int fr);
    check({tag, "_sv"},    int'(stats_valid), sv);
    check({tag, "_dc0"},   int'($signed(dc[0 +: DW])), d0);
    check({tag, "_dc1"},   int'($signed(dc[DW +: DW])), d1);
    check({tag, "_mag0"},  int'(mag[0 +: HW]), g0);
    check({tag, "_mag1"},  int'(mag[HW +: HW]), g1);
    check({tag, "_frame"}, int'(frame), fr);
  endtask

  function automatic int rnd_sample();
    int r;
    r = $urandom % 8;
    if (r == 0) return -128;
    if (r == 1) return 127;
    return int'($signed(8'($urandom)));
  endfunction

  typedef struct {
    int xa0, xb0, xa1, xb1;  // even / odd sample per channel
    int th;
    int gap;                 // 1: invalid cycle with garbage x between samples
    int edc0, edc1, emag0, emag1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{xa0:   5, xb0:   5, xa1:   -3, xb1:   -3, th:   4, gap: 0, edc0:  40, edc1:   -24, emag0: 15, emag1: 0};
    tbl[1] = '{xa0:   5, xb0:   5, xa1:   -3, xb1:   -3, th:   4, gap: 1, edc0:  40, edc1:   -24, emag0: 15, emag1: 0};
    tbl[2] = '{xa0:-128, xb0: 127, xa1: -128, xb1:  127, th: 127, gap: 0, edc0:  -4, edc1:    -4, emag0: 15, emag1: 15};
    tbl[3] = '{xa0:   0, xb0:   0, xa1:   -1, xb1:   -1, th:   0, gap: 0, edc0:   0, edc1:    -8, emag0: 15, emag1: 15};
    tbl[4] = '{xa0:   3, xb0:  -3, xa1:    2, xb1:    3, th:   3, gap: 0, edc0:   0, edc1:    20, emag0: 15, emag1: 8};
    tbl[5] = '{xa0:  -1, xb0:   0, xa1: -128, xb1: -128, th:   1, gap: 1, edc0:  -4, edc1: -1024, emag0:  8, emag1: 15};

    model_full_reset();

    // Reset state, asserted before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven full windows.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < WIN; i++) begin
        if (tbl[r].gap != 0 && i > 0)
          step(int'($urandom % 256), int'($urandom % 256), 1'b0, tbl[r].th, 1'b0);
        if (i % 2 == 0) step(tbl[r].xa0, tbl[r].xa1, 1'b1, tbl[r].th, 1'b0);
        else            step(tbl[r].xb0, tbl[r].xb1, 1'b1, tbl[r].th, 1'b0);
      end
      pubs++;
      check_pub($sformatf("tbl%0d", r), 1, tbl[r].edc0, tbl[r].edc1, tbl[r].emag0, tbl[r].emag1, pubs);
      step(0, 0, 1'b0, tbl[r].th, 1'b0);
      check($sformatf("tbl%0d_pulse_end", r), int'(stats_valid), 0);
    end

    // Clear after the 10th sample: sample 16 must not publish.
    for (int i = 0; i < 10; i++) step(7, -9, 1'b1, 5, 1'b0);
    step(7, -9, 1'b0, 5, 1'b1);
    for (int i = 0; i < 6; i++) step(7, -9, 1'b1, 5, 1'b0);
    check_pub("clr_hold", 0, -4, -1024, 8, 15, pubs);
    for (int i = 0; i < 10; i++) step(7, -9, 1'b1, 5, 1'b0);
    pubs++;
    check_pub("clr_pub", 1, 56, -72, 15, 15, pubs);

    // Clear together with the completing sample.
    for (int i = 0; i < 15; i++) step(2, 1, 1'b1, 2, 1'b0);
    step(2, 1, 1'b1, 2, 1'b1);
    check_pub("coll", 0, 56, -72, 15, 15, pubs);
    for (int i = 0; i < WIN; i++) step(2, 1, 1'b1, 2, 1'b0);
    pubs++;
    check_pub("coll_pub", 1, 16, 8, 15, 0, pubs);

    // Randomized traffic: gaps, threshold changes, occasional clears.
    begin
      int th;
      th = 40;
      for (int i = 0; i < 900; i++) begin
        if ($urandom % 16 == 0) begin
          case ($urandom % 4)
            0: th = 0;
            1: th = 127;
            default: th = int'($urandom % 128);
          endcase
        end
        step(rnd_sample(), rnd_sample(), ($urandom % 4) != 0, th, ($urandom % 64) == 0);
      end
    end

    // Asynchronous reset mid-window with the clock stopped.
    for (int i = 0; i < 7; i++) step(rnd_sample(), rnd_sample(), 1'b1, 10, 1'b0);
    @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dc", int'(dc), 0);
    check("arst_mag", int'(mag), 0);
    check("arst_frame", int'(frame), 0);
    check("arst_sv", int'(stats_valid), 0);
    model_full_reset();
    #5 rst_n = 1'b1;
    #5 clk_run = 1'b1;
    for (int i = 0; i < 15; i++) step(1, -1, 1'b1, 1, 1'b0);
    check_pub("arst_partial", 0, 0, 0, 0, 0, 0);
    step(1, -1, 1'b1, 1, 1'b0);
    check_pub("arst_pub", 1, 8, -8, 15, 15, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_stats.md
SAMPLE_STATS -- requirements
Module: sample_stats

Interface
REQ-001 The block SHALL have the parameters listed in REQ-002 to REQ-006.
REQ-002 NCH, default 2: number of sample channels.
REQ-003 W, default 8: sample width, two's complement.
REQ-004 LOG2N, default 19: the window is 2^LOG2N valid samples; legal range 1..24.
REQ-005 FRAC, default 3: fractional bits kept on the mean output; SHALL satisfy FRAC <= LOG2N.
REQ-006 HW, default 8: histogram output width; SHALL satisfy HW <= LOG2N.
REQ-007 Ports SHALL be as listed in REQ-008 to REQ-016.
REQ-008 clk, input, 1: sole clock, rising edge.
REQ-009 rst_n, input, 1: asynchronous, active-low reset.
REQ-010 x, input, NCH*W: samples; channel c occupies x[c*W +: W].
REQ-011 x_valid, input, 1: all channels' samples are valid this cycle.
REQ-012 thresh, input, W-1: unsigned magnitude threshold, shared by all channels.
REQ-013 clear, input, 1: synchronous window restart.
REQ-014 dc, output, NCH*(W+FRAC): per-channel windowed mean, signed, with FRAC fractional bits.
REQ-015 mag, output, NCH*HW: per-channel fraction of samples with magnitude >= thresh.
REQ-016 stats_valid and frame: stats_valid is a 1-bit output pulse marking a new result; frame is an 8-bit output publish counter.

Function
REQ-017 The block SHALL keep one shared window counter of LOG2N bits that increments only on cycles with x_valid=1.
REQ-018 Each channel SHALL have a signed accumulator of W+LOG2N bits that adds the sign-extended sample on every x_valid cycle; it cannot overflow over one window.
REQ-019 A channel sample counts as "high" iff x >= thresh or x <= -thresh, evaluated in W+1-bit signed arithmetic; the most-negative code is therefore handled exactly, and thresh=0 makes every sample high.
REQ-020 Each channel SHALL have a high-count counter of LOG2N+1 bits that increments on valid high samples.
REQ-021 The window completes on the edge where x_valid=1 and the counter equals 2^LOG2N-1 (the completing sample). On that edge the block SHALL:
  - publish results that include the completing sample;
  - set the window counter, accumulators and high counts to 0;
  - increment frame, wrapping 255 -> 0.
REQ-022 Published dc[c] SHALL be (acc + sample)[W+LOG2N-1 : LOG2N-FRAC], i.e. the mean * 2^FRAC truncated toward minus infinity.
REQ-023 Published mag[c] SHALL be (count >> (LOG2N-HW)), saturated to 2^HW-1; an all-high window gives 2^HW-1.
REQ-024 stats_valid SHALL be high for exactly the one cycle following a publish edge; dc, mag and frame change only on publish edges and hold otherwise.
REQ-025 Latency: results SHALL be visible on the outputs one clock after the completing sample is sampled.
REQ-026 Cycles with x_valid=0 SHALL leave the counter, accumulators and high counts unchanged, regardless of the value on x.
REQ-027 clear=1 SHALL zero the window counter, accumulators and high counts on the next edge, discard the partial window, and leave dc, mag and frame unchanged.
REQ-028 If clear=1 coincides with a completing sample, clear SHALL win: no publish, no stats_valid pulse, no frame increment.
REQ-029 A thresh change mid-window SHALL take effect from the next valid sample, with no restart.

Reset
REQ-030 While rst_n=0, all of the following SHALL be 0 immediately, without waiting for a clock edge: window counter, accumulators, high counts, dc, mag, frame and stats_valid.
REQ-031 After rst_n deassertion, the first window SHALL start with the first valid sample.

Verification (NCH=2, W=8, LOG2N=4, FRAC=3, HW=4)
REQ-032 Constant window: x0=5, x1=-3, x_valid=1 continuously, thresh=4 -> one stats_valid pulse after 16 samples; dc0=40, dc1=-24, mag0=15 (16 saturated), mag1=0, frame=1.
REQ-033 Gapped valid: the same samples with x_valid asserted every other cycle -> pulse after 32 cycles with identical results; x values during invalid cycles are ignored.
REQ-034 Extremes: alternating -128/127 on both channels, thresh=127 -> dc=-4 (mean -0.5), mag=15.
REQ-035 Clear: clear pulsed after the 10th sample -> no pulse at sample 16; the next pulse comes 16 valid samples after the clear, and the outputs in between keep their prior values.
REQ-036 Clear collision: clear asserted together with the 16th sample -> no pulse, outputs and frame unchanged.
REQ-037 Asynchronous reset: rst_n dropped mid-window with the clock stopped -> dc, mag, frame and stats_valid read 0 at once, and a full fresh window is needed before the next pulse.
